// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed scan controller for an 8-digit seven-segment display.
//   It steps a 3-bit digit select to an external 8:1 digit mux. It decodes the
//   returned 4-bit value to segments. It drives one-hot anodes, and every
//   digit slot starts with a blank phase in which all anodes are off.
//
//   Optional feature: define SCAN_LZB_EN to enable leading-zero blanking.
//
//   Parameters
//     CLK_DIV    clk cycles per digit slot (>= 4)
//     BLANK_CYC  anode-off cycles at the start of each slot (1 <= BLANK_CYC < CLK_DIV)
//     ACTIVE_LOW 1: an_o/seg_o/dp_o active-low, 0: active-high
//
//   Ports
//     clk       system clock
//     rst       asynchronous active-high reset
//     en        scan enable
//     dig_mask  per-digit display enable (bit n = digit n)
//     dp_i      per-digit decimal point request
//     data_i    digit value returned combinationally by the mux for sel_o
//     sel_o     digit select to the mux, scans 7 down to 0
//     an_o      digit anodes, one-hot when active
//     seg_o     segments, bit0=a .. bit6=g
//     dp_o      decimal point segment
//     frame_o   one-cycle pulse when sel_o reloads 7 after 0
module seg_scan_driver #(
   parameter int CLK_DIV    = 50000,
   parameter int BLANK_CYC  = 16,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] dig_mask,
   input  logic [7:0] dp_i,
   input  logic [3:0] data_i,
   output logic [2:0] sel_o,
   output logic [7:0] an_o,
   output logic [6:0] seg_o,
   output logic       dp_o,
   output logic       frame_o
);

   localparam int CW = $clog2(CLK_DIV);

   // Inactive ("off") levels for the display pins.
   localparam logic [7:0] AN_OFF  = {8{ACTIVE_LOW}};
   localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
   localparam logic       DP_OFF  = ACTIVE_LOW;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    sel_q, sel_d;
   logic          frame_q, frame_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          wrap;
   logic          blank;
   logic [7:0]    sel_onehot;
   logic [6:0]    seg_raw;

   assign wrap = (cnt_q == CW'(CLK_DIV - 1));

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
         assign sel_onehot[gi] = (sel_q == 3'(gi));
      end
   endgenerate

   // Hex to segments, active-high, bit6..bit0 = g..a.
   always_comb begin
      seg_raw = 7'h00;
      case (data_i)
         4'h0: seg_raw = 7'h3F;
         4'h1: seg_raw = 7'h06;
         4'h2: seg_raw = 7'h5B;
         4'h3: seg_raw = 7'h4F;
         4'h4: seg_raw = 7'h66;
         4'h5: seg_raw = 7'h6D;
         4'h6: seg_raw = 7'h7D;
         4'h7: seg_raw = 7'h07;
         4'h8: seg_raw = 7'h7F;
         4'h9: seg_raw = 7'h6F;
         4'hA: seg_raw = 7'h77;
         4'hB: seg_raw = 7'h7C;
         4'hC: seg_raw = 7'h39;
         4'hD: seg_raw = 7'h5E;
         4'hE: seg_raw = 7'h79;
         default: seg_raw = 7'h71;
      endcase
   end

`ifdef SCAN_LZB_EN
   // lz_q: every digit scanned so far in this frame was zero.
   // lzb_q: blank decision for the current slot, taken at cnt==0. It is only
   // consulted once cnt>=BLANK_CYC>=1, so it is always up to date by then.
   logic lz_q, lz_d;
   logic lzb_q, lzb_d;

   always_comb begin
      lz_d  = lz_q;
      lzb_d = lzb_q;
      if (en) begin
         if (cnt_q == '0) begin
            lzb_d = lz_q && (data_i == 4'h0) && (sel_q != 3'd0);
            lz_d  = lz_q && (data_i == 4'h0);
         end
         if (wrap && sel_q == 3'd0) begin
            lz_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lz_q  <= 1'b1;
         lzb_q <= 1'b0;
      end else begin
         lz_q  <= lz_d;
         lzb_q <= lzb_d;
      end
   end

   assign blank = lzb_q;
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      frame_d = 1'b0;
      an_d    = AN_OFF;
      seg_d   = SEG_OFF;
      dp_d    = DP_OFF;
      if (en) begin
         if (wrap) begin
            cnt_d   = '0;
            sel_d   = sel_q - 3'd1;       // 0 wraps to 7
            frame_d = (sel_q == 3'd0);
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         seg_d = seg_raw ^ {7{ACTIVE_LOW}};
         dp_d  = dp_i[sel_q] ^ ACTIVE_LOW;
         // The anode registers alongside the segments for the same sel_q.
         // The blank phase covers the cycle in which seg_o still shows the
         // previous digit.
         if (cnt_q >= CW'(BLANK_CYC) && dig_mask[sel_q] && !blank) begin
            an_d = sel_onehot ^ {8{ACTIVE_LOW}};
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         sel_q   <= 3'd7;
         frame_q <= 1'b0;
         an_q    <= AN_OFF;
         seg_q   <= SEG_OFF;
         dp_q    <= DP_OFF;
      end else begin
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         frame_q <= frame_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign sel_o   = sel_q;
   assign an_o    = an_q;
   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

   localparam int CLK_DIV   = 8;
   localparam int BLANK_CYC = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] dig_mask;
   logic [7:0] dp_i;
   logic [3:0] data_i;
   logic [2:0] sel_o;
   logic [7:0] an_o;
   logic [6:0] seg_o;
   logic       dp_o;
   logic       frame_o;

   logic [3:0] vals [8];      // digit registers behind the external mux
   logic [6:0] dec_tab [16];

   int tests = 0;
   int fails = 0;

   // reference model: current digit and position within its slot
   int   m_digit, m_pos;
   bit   m_lz, m_blank;
   bit   lzb_on;
   logic [7:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp, e_frame;

   always #5 clk = ~clk;

   assign data_i = vals[sel_o];

   seg_scan_driver #(
      .CLK_DIV   (CLK_DIV),
      .BLANK_CYC (BLANK_CYC),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .dig_mask(dig_mask),
      .dp_i    (dp_i),
      .data_i  (data_i),
      .sel_o   (sel_o),
      .an_o    (an_o),
      .seg_o   (seg_o),
      .dp_o    (dp_o),
      .frame_o (frame_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_digit = 7;
      m_pos   = 0;
      m_lz    = 1'b1;
      m_blank = 1'b0;
      e_an    = 8'hFF;
      e_seg   = 7'h7F;
      e_dp    = 1'b1;
      e_frame = 1'b0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".sel"},   32'(sel_o),   32'(m_digit));
      check({tag, ".an"},    32'(an_o),    32'(e_an));
      check({tag, ".seg"},   32'(seg_o),   32'(e_seg));
      check({tag, ".dp"},    32'(dp_o),    32'(e_dp));
      check({tag, ".frame"}, 32'(frame_o), 32'(e_frame));
   endtask

   // One clock: predict what the outputs show after the edge, advance, compare.
   task automatic step(input string tag);
      int v;
      bit on;
      if (en) begin
         v = int'(vals[m_digit]);
         if (m_pos == 0) begin
            m_blank = lzb_on && m_lz && (v == 0) && (m_digit != 0);
            m_lz    = m_lz && (v == 0);
         end
         on      = (m_pos >= BLANK_CYC) && dig_mask[m_digit] && !m_blank;
         e_an    = on ? ~(8'd1 << m_digit) : 8'hFF;
         e_seg   = ~dec_tab[v];
         e_dp    = ~dp_i[m_digit];
         e_frame = 1'b0;
         if (m_pos == CLK_DIV - 1) begin
            m_pos = 0;
            if (m_digit == 0) begin
               e_frame = 1'b1;
               m_digit = 7;
               m_lz    = 1'b1;
            end else begin
               m_digit = m_digit - 1;
            end
         end else begin
            m_pos = m_pos + 1;
         end
      end else begin
         e_an    = 8'hFF;
         e_seg   = 7'h7F;
         e_dp    = 1'b1;
         e_frame = 1'b0;
         m_pos   = 0;
      end
      @(posedge clk);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int frames;
      logic [7:0] seen;
      bit found;

      dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      lzb_on = 1'b0;
`ifdef SCAN_LZB_EN
      lzb_on = 1'b1;
`endif
      for (int i = 0; i < 8; i++) vals[i] = 4'(i);
      rst = 1'b1; en = 1'b0; dig_mask = 8'hFF; dp_i = 8'h00;
      model_reset();

      // reset state
      #12;
      check("rst.sel",   32'(sel_o),   32'd7);
      check("rst.an",    32'(an_o),    32'hFF);
      check("rst.seg",   32'(seg_o),   32'h7F);
      check("rst.dp",    32'(dp_o),    32'd1);
      check("rst.frame", 32'(frame_o), 32'd0);

      // basic scan, digit n = n
      @(negedge clk);
      rst = 1'b0; en = 1'b1;
      model_reset();
      frames = 0;
      for (int k = 0; k < 128; k++) begin
         step("scan");
         if (frame_o) frames++;
         if (an_o == 8'hFE) check("seg_d0", 32'(seg_o), 32'h40);
         if (an_o == 8'hF7) check("seg_d3", 32'(seg_o), 32'h30);
      end
      check("frames_128", 32'(frames), 32'd2);

      // upper digits only, dp requested on digit 0
      dig_mask = 8'hF0; dp_i = 8'h01;
      frames = 0; seen = 8'h00;
      for (int k = 0; k < 64; k++) begin
         step("mask");
         if (frame_o) frames++;
         seen = seen | ~an_o;
      end
      check("mask_low_an", 32'(seen & 8'h0F), 32'd0);
      check("mask_frames", 32'(frames), 32'd1);

      // randomized contents, masks, dp and enable gaps
      for (int c = 0; c < 24; c++) begin
         for (int i = 0; i < 8; i++) vals[i] = 4'($urandom_range(0, 15));
         dig_mask = 8'($urandom);
         dp_i     = 8'($urandom);
         en       = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 13; k++) step("rand");
      end

      // asynchronous reset mid-slot at sel=4, cnt=5
      en = 1'b1; dig_mask = 8'hFF; dp_i = 8'h00;
      for (int i = 0; i < 8; i++) vals[i] = 4'(i);
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         step("seek4");
         found = (m_digit == 4 && m_pos == 5);
      end
      if (!found) begin
         tests++; fails++;
         $error("FAIL seek4 observed=timeout expected=sel4_cnt5");
      end
      check("pre_rst.an", 32'(an_o), 32'hEF);
      #2 rst = 1'b1;
      #1;
      check("async_rst.an",  32'(an_o),  32'hFF);
      check("async_rst.seg", 32'(seg_o), 32'h7F);
      check("async_rst.dp",  32'(dp_o),  32'd1);
      check("async_rst.sel", 32'(sel_o), 32'd7);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 16; k++) step("post_rst");

      // enable gap at sel=5
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         step("seek5");
         found = (m_digit == 5 && m_pos == 3);
      end
      if (!found) begin
         tests++; fails++;
         $error("FAIL seek5 observed=timeout expected=sel5_cnt3");
      end
      en = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step("en_off");
         check("en_off.sel5", 32'(sel_o), 32'd5);
         check("en_off.anFF", 32'(an_o), 32'hFF);
      end
      en = 1'b1;
      step("reen0");
      check("reen_blank0", 32'(an_o), 32'hFF);
      step("reen1");
      check("reen_blank1", 32'(an_o), 32'hFF);
      step("reen2");
      check("reen_on", 32'(an_o), 32'hDF);
      for (int k = 0; k < 20; k++) step("reen_run");

`ifdef SCAN_LZB_EN
      // leading-zero blanking: digits 7..0 = 0,0,0,4,0,0,0,0
      for (int i = 0; i < 8; i++) vals[i] = 4'h0;
      vals[4] = 4'h4;
      do_reset();
      seen = 8'h00;
      for (int k = 0; k < 128; k++) begin
         step("lzb");
         seen = seen | ~an_o;
      end
      check("lzb_seen", 32'(seen), 32'h1F);
      vals[4] = 4'h0;
      do_reset();
      seen = 8'h00;
      for (int k = 0; k < 128; k++) begin
         step("lzb0");
         seen = seen | ~an_o;
      end
      check("lzb_all0_seen", 32'(seen), 32'h01);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed scan controller for an 8-digit seven-segment display.
- It is the driving end of the 8:1 4-bit digit mux: generates the 3-bit digit select (sel_o) and consumes the selected 4-bit digit (data_i).
- Decodes that digit to segments and drives one-hot digit anodes, with a dead-time blank at every digit switch to suppress ghosting.
- Sits between the digit-value registers / mux and the display pins.

Parameters:
- CLK_DIV, 50000: clk cycles per digit slot. Must be >= 4.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off. Must satisfy 1 <= BLANK_CYC < CLK_DIV.
- ACTIVE_LOW, 1: 1 means an_o, seg_o and dp_o are active-low; 0 means active-high.

Ports:
- clk in 1: system clock.
- rst in 1: asynchronous, active-high reset.
- en in 1: scan enable.
- dig_mask in 8: per-digit display enable; bit n = digit n.
- dp_i in 8: per-digit decimal point request.
- data_i in 4: selected digit value, returned combinationally by the mux from sel_o.
- sel_o out 3: digit select to the mux.
- an_o out 8: digit anode drives, one-hot when active.
- seg_o out 7: segments; bit0=a … bit6=g.
- dp_o out 1: decimal point segment.
- frame_o out 1: one-cycle pulse at the start of each full 8-digit frame.

Behaviour:
- "Off" below means the inactive level given ACTIVE_LOW: all-ones when ACTIVE_LOW=1, zeros when ACTIVE_LOW=0.
- Reset (async, any time, including mid-slot):
  - cnt=0, sel_o=7, frame_o=0.
  - an_o, seg_o and dp_o all off.
  - The first slot after reset release is digit 7.
- Slot counter cnt, 0..CLK_DIV-1:
  - Increments when en=1.
  - At cnt==CLK_DIV-1 it wraps to 0, and sel_o steps in descending order 7→6→…→0→7.
  - frame_o=1 for exactly the cycle in which sel_o is loaded 7 after 0.
- en=0:
  - cnt is cleared to 0 and sel_o holds.
  - an_o, seg_o and dp_o go off on the next edge.
  - When en returns to 1, the held digit restarts a full slot, including the blank phase.
- Output pipeline (all outputs registered):
  - seg_o and dp_o are registered from data_i and dp_i[sel_o], so they follow sel_o with 1-cycle latency.
  - an_o[n] is active on the next edge only if all of the following hold: en=1, sel_o==n, cnt>=BLANK_CYC, dig_mask[n]=1, and the digit is not blanked by the optional feature.
  - Otherwise all an_o bits are off.
  - Because BLANK_CYC >= 1, no anode is ever active while seg_o still shows the previous digit.
- Decode table, segments a..g on, written as bit6..bit0 active-high before polarity is applied:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Masked digit: its slot is still consumed (fixed frame timing), but the anode stays off for the whole slot.
- dig_mask and dp_i changes take effect on the next clk edge; no resynchronisation is required.
- Timing: frame period = 8*CLK_DIV cycles; each digit's anode is on for CLK_DIV-BLANK_CYC cycles per frame.

Optional Feature:
- Macro: SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Internal flag lz is set to 1 whenever sel_o is loaded 7, and on reset.
  - At cnt==0 of each slot, the slot is blanked if lz==1, data_i==0 and sel_o!=0. Blanked means anode off for the whole slot.
  - lz is then updated to lz & (data_i==0).
  - Digit 0 is never blanked.
  - dig_mask does not influence lz.
- Not defined: lz logic is absent; every unmasked digit is displayed, including zeros.

Test Plan:
- Common setup: CLK_DIV=8, BLANK_CYC=2, ACTIVE_LOW=1.
- Reset, then en=1 and dig_mask=FF:
  - sel_o runs 7,6,…,0,7 with 8 clk per value.
  - frame_o pulses once every 64 clk.
  - an_o stays FF for cycles 0-1 of each slot and equals ~(1<<sel) for cycles 2-7.
- Mux digits set to 0..7 (digit n = n):
  - While an_o=FE, seg_o=~3F (7'h40).
  - While an_o=F7, seg_o=~4F (7'h30).
  - seg_o changes exactly 1 clk after sel_o.
- dig_mask=F0, dp_i=01:
  - an_o[3:0] never asserted; frame period still 64 clk.
  - dp_o=0 (on) only during the digit-0 slot. Because digit 0 is masked, its anode is never on, so the dp is never displayed.
- Assert rst mid-slot (sel_o=4, cnt=5):
  - Outputs go off immediately, without waiting for a clk edge.
  - After release: sel_o=7, cnt=0.
- en deasserted for 20 clk at sel_o=5:
  - sel_o holds 5 and an_o=FF throughout.
  - After re-enable: 2 blank cycles, then an_o=DF.
- SCAN_LZB_EN defined, digits 7..0 = 0,0,0,4,0,0,0,0:
  - Anodes for digits 7,6,5 stay off; digits 4,3,2,1,0 display.
  - With all digits 0, only digit 0 displays.
